// File: rtl/rptr_ctrl_v2_pkg.sv
// Shared pointer types and Gray/binary helpers for the JTAG async FIFO.
// The helpers operate on a wide zero-extended vector so any pointer width up
// to MAX_PTR_W can use them; callers cast the result back to their width.
package rptr_ctrl_v2_pkg;

    localparam int unsigned MAX_PTR_W    = 32;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_PTR_W    = DEF_ADDR_W + 1;

    typedef logic [MAX_PTR_W-1:0] wide_ptr_t;
    typedef logic [DEF_PTR_W-1:0] ptr_t;

    // Binary to reflected Gray code.
    function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary as a prefix XOR from the MSB down.
    function automatic wide_ptr_t gray2bin(input wide_ptr_t gray);
        wide_ptr_t bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_ctrl_v2_if.sv
// Read-side pointer controller bus.
// master: pop request, synchronised Gray write pointer, sticky-flag clear.
// slave : Gray read pointer, RAM address, empty/almost-empty, fill count,
//         sticky underflow and pointer-error flags.
interface rptr_ctrl_v2_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic                  rinc;
    logic [PTR_W-1:0]      sync_wptr;
    logic                  err_clr;
    logic [PTR_W-1:0]      rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_W-1:0]      rcount;
    logic                  underflow;
    logic                  ptr_err;

    modport master (
        output rinc, sync_wptr, err_clr,
        input  rptr, raddr, empty, almost_empty, rcount, underflow, ptr_err
    );

    modport slave (
        input  rinc, sync_wptr, err_clr,
        output rptr, raddr, empty, almost_empty, rcount, underflow, ptr_err
    );
endinterface

// File: rtl/rptr_ctrl_v2_gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared with the write-side controller.
// Ports: i_gray (W bits Gray code), o_bin (W bits binary).
module gray2bin_conv
    import rptr_ctrl_v2_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    assign o_bin = W'(gray2bin(MAX_PTR_W'(i_gray)));

endmodule

// File: rtl/rptr_ctrl_v2.sv
// Read-domain pointer controller for the JTAG async FIFO.
// Ports: rclk (read clock), r_rst (async active-high reset),
//        bus (slave modport: pop/sync_wptr/err_clr in; rptr/raddr/flags/count out).
// All outputs are registered; flags are computed from the next read pointer and
// the current synchronised write pointer so a pop is reflected immediately.
module rptr_ctrl_v2
    import rptr_ctrl_v2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic          rclk,
    input  logic          r_rst,
    rptr_ctrl_v2_if.slave bus
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rgray;
    logic             r_empty;
    logic             r_almost_empty;
    logic [PTR_W-1:0] r_rcount;
    logic             r_underflow;
    logic             r_ptr_err;

    logic             w_pop;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic [PTR_W-1:0] w_dist;
    logic             w_dist_over;

    // Decode the synchronised write pointer back to binary.
    gray2bin_conv #(.W(PTR_W)) u_wconv (
        .i_gray (bus.sync_wptr),
        .o_bin  (w_wbin)
    );

    // Next pointer and distance; subtraction wraps naturally at PTR_W bits.
    assign w_pop        = bus.rinc & ~r_empty;
    assign w_rbin_next  = r_rbin + PTR_W'(w_pop);
    assign w_rgray_next = PTR_W'(bin2gray(MAX_PTR_W'(w_rbin_next)));
    assign w_dist       = w_wbin - w_rbin_next;
    assign w_dist_over  = (w_dist > PTR_W'(DEPTH));

    // Pointer, flag and count registers; sticky flags favour set over clear.
    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rcount       <= '0;
            r_underflow    <= 1'b0;
            r_ptr_err      <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= (w_rgray_next == bus.sync_wptr);
            r_almost_empty <= (w_dist <= PTR_W'(AE_THRESH));
            r_rcount       <= w_dist_over ? PTR_W'(DEPTH) : w_dist;
            r_underflow    <= (bus.rinc & r_empty) | (r_underflow & ~bus.err_clr);
            r_ptr_err      <= w_dist_over | (r_ptr_err & ~bus.err_clr);
        end
    end

    assign bus.rptr         = r_rgray;
    assign bus.raddr        = r_rbin[ADDR_WIDTH-1:0];
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rcount       = r_rcount;
    assign bus.underflow    = r_underflow;
    assign bus.ptr_err      = r_ptr_err;

endmodule
